// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared state encoding and default widths for mux_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int DW_DEF    = 5;
    localparam int N_REQ_DEF = 4;

    typedef enum logic [0:0] {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_if
// Description : Source request/data and downstream valid/ready bundle.
//               Carries the lock input when MUX_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 5
);
    localparam int SEL_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] din;
    logic                out_ready;
    logic                out_valid;
    logic [DW-1:0]       dout;
    logic [N_REQ-1:0]    grant;
    logic [SEL_W-1:0]    sel;
    logic                busy;
`ifdef MUX_ARB_LOCK_EN
    logic                lock;
`endif

    modport slave (
        input  req, din, out_ready,
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        output out_valid, dout, grant, sel, busy
    );

    modport master (
        output req, din, out_ready,
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        input  out_valid, dout, grant, sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick: first set req bit at or after
//               ptr, via rotate / priority-encode / rotate-back.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [SEL_W-1:0] ptr,
    output logic      [N_REQ-1:0] winner,
    output logic      [SEL_W-1:0] index,
    output logic                  any_req
);
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_enc;

    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_enc = SEL_W'(i);
        end
    end

    // Rotating back wraps naturally since N_REQ is a power of two.
    assign index   = w_enc + ptr;
    assign any_req = |req;
    assign winner  = any_req ? (N_REQ'(1) << index) : '0;

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter owning a shared DW-bit mux, registered
//               output word with valid/ready. Option macro: MUX_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    mux_rr_arbiter_if.slave  bus
);
    localparam int SEL_W = $clog2(N_REQ);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt, w_pick_ptr, w_adv;
    logic [SEL_W-1:0] r_sel;
    logic [N_REQ-1:0] r_grant;
    logic [DW-1:0]    r_dout;
    logic             w_load, w_clear;
    logic [N_REQ-1:0] w_win;
    logic [SEL_W-1:0] w_idx;
    logic             w_any;
    logic [DW-1:0]    w_word;

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
        .req     (bus.req),
        .ptr     (w_pick_ptr),
        .winner  (w_win),
        .index   (w_idx),
        .any_req (w_any)
    );

`ifdef MUX_ARB_LOCK_EN
    // Holding ptr at the current source makes the picker re-grant it first.
    assign w_adv = (bus.lock && bus.req[r_sel]) ? r_sel : r_sel + 1'b1;
`else
    assign w_adv = r_sel + 1'b1;
`endif

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == SEL_W'(i)) w_word = bus.din[i*DW +: DW];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_pick_ptr  = r_ptr;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (bus.out_ready) begin
                    w_ptr_nxt  = w_adv;
                    w_pick_ptr = w_adv;
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_load) begin
                r_dout  <= w_word;
                r_grant <= w_win;
                r_sel   <= w_idx;
            end else if (w_clear) begin
                r_grant <= '0;
            end
        end
    end

    assign bus.out_valid = (r_state == S_GRANT);
    assign bus.busy      = (r_state == S_GRANT);
    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter (N_REQ=4, DW=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 5;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;
    bit   chk_en;

    mux_rr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    mux_rr_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan sources from ptr upward, mod N.
    bit m_valid;
    int m_src;
    int m_word;
    int m_ptr;

    function automatic bit lock_now();
`ifdef MUX_ARB_LOCK_EN
        return bus.lock;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid = 0; m_src = 0; m_word = 0; m_ptr = 0;
        end else if (!m_valid || bus.out_ready) begin
            logic [N*DW-1:0] d;
            logic [N-1:0]    r;
            bit              found;
            d = bus.din;
            r = bus.req;
            if (m_valid)
                m_ptr = (lock_now() && r[m_src]) ? m_src : (m_src + 1) % N;
            found = 0;
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (!found && r[s]) begin
                    found  = 1;
                    m_src  = s;
                    m_word = int'(d[s*DW +: DW]);
                end
            end
            m_valid = found;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rstn) begin
            check("model_valid", int'(bus.out_valid), int'(m_valid));
            check("model_busy",  int'(bus.busy),      int'(m_valid));
            check("model_grant", int'(bus.grant),     m_valid ? (1 << m_src) : 0);
            if (m_valid) begin
                check("model_sel",  int'(bus.sel),  m_src);
                check("model_dout", int'(bus.dout), m_word);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int s, input int v);
        logic [N*DW-1:0] d;
        d = bus.din;
        d[s*DW +: DW] = DW'(v);
        bus.din = d;
    endtask

    initial begin
        int exp_seq [4];
        n_cmp = 0; n_bad = 0; chk_en = 0;
        rstn = 1'b0;
        bus.req = 4'b1111;
        bus.din = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_dout",  int'(bus.dout),      0);
        check("rst_grant", int'(bus.grant),     0);
        check("rst_busy",  int'(bus.busy),      0);
        rstn = 1'b1;
        chk_en = 1;
        step();
        check("first_grant", int'(bus.grant), 1);
        check("first_sel",   int'(bus.sel),   0);
        check("first_dout",  int'(bus.dout),  1);

        // Round-robin over all four sources.
        bus.out_ready = 1'b1;
        exp_seq = '{2, 3, 4, 1};
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_dout",  int'(bus.dout),      exp_seq[i]);
            check("rr_valid", int'(bus.out_valid), 1);
        end

        // Backpressure on a single source.
        bus.req = 4'b0100;
        set_src(2, 7);
        step();
        bus.out_ready = 1'b0;
        check("bp_first", int'(bus.dout), 7);
        set_src(2, 9);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_dout",  int'(bus.dout),  7);
            check("bp_hold_grant", int'(bus.grant), 4);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_next", int'(bus.dout), 9);
        step();

        // Sparse request with wrap: set ptr=1 first.
        rstn = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
        bus.req = 4'b0001;
        step();
        check("sp_g0", int'(bus.grant), 1);
        bus.req = 4'b1001;
        bus.out_ready = 1'b1;
        step();
        check("sp_g3", int'(bus.grant), 8);
        step();
        check("sp_wrap", int'(bus.grant), 1);
        bus.req = 4'b0000;
        step();
        check("sp_idle_valid", int'(bus.out_valid), 0);
        check("sp_idle_grant", int'(bus.grant),     0);
        step();
        check("rdy_ignored", int'(bus.out_valid), 0);

        // Asynchronous reset between edges.
        bus.req = 4'b0010;
        bus.out_ready = 1'b0;
        step();
        check("ar_pre", int'(bus.grant), 2);
        #2 rstn = 1'b0;
        #1;
        check("ar_valid", int'(bus.out_valid), 0);
        check("ar_grant", int'(bus.grant),     0);
        check("ar_busy",  int'(bus.busy),      0);
        #1 rstn = 1'b1;
        step();
        check("ar_regrant", int'(bus.grant), 2);

`ifdef MUX_ARB_LOCK_EN
        rstn = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
        bus.req = 4'b0011;
        bus.lock = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("lock_src0", int'(bus.grant), 1);
        end
        bus.lock = 1'b0;
        step();
        check("unlock_src1", int'(bus.grant), 2);
`endif

        bus.req = 4'b0000;
        repeat (3) step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
